// File: rtl/scr1_tcm_dport_arb.sv
// TCM port-B arbiter: shares the data port between the core dmem interface and the
// accelerator, composes core byte lanes and routes each read response back to its owner.
module scr1_tcm_dport_arb #(
  parameter logic [31:0] TCM_SIZE     = 32'h00010000,
  parameter int          ACC_MAX_WAIT = 4,
  parameter int          IDX_W        = $clog2(TCM_SIZE) - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             core_req,
  input  logic             core_cmd,
  input  logic [1:0]       core_width,
  input  logic [31:0]      core_addr,
  input  logic [31:0]      core_wdata,
  output logic             core_req_ack,
  output logic [31:0]      core_rdata,
  output logic [1:0]       core_resp,
  input  logic             acc_req,
  input  logic             acc_we,
  input  logic [3:0]       acc_be,
  input  logic [IDX_W-1:0] acc_addr,
  input  logic [31:0]      acc_wdata,
  output logic             acc_gnt,
  output logic             acc_rvalid,
  output logic [31:0]      acc_rdata,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic [3:0]       mem_be,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {
    RESP_NOTRDY = 2'd0,
    RESP_RDY_OK = 2'd1,
    RESP_RDY_ER = 2'd2
  } resp_e;

  localparam logic [3:0] MAX_WAIT = 4'(ACC_MAX_WAIT);

  logic        core_err;
  logic        acc_win;
  logic        core_win;
  logic        core_legal;
  logic [3:0]  core_be;
  logic [31:0] core_wd;
  logic [3:0]  starve_cnt;
  resp_e       resp_q;
  logic        core_rd_pend;
  logic [1:0]  core_shift;
  logic [31:0] core_rdata_q;
  logic        acc_rd_pend;

  assign core_err = core_req & ((core_addr >= TCM_SIZE)
                              | ((core_width == 2'd1) & core_addr[0])
                              | ((core_width == 2'd2) & (core_addr[1:0] != 2'b00)));

  // A starved accelerator overrides the core's default priority.
  assign acc_win    = acc_req & ((starve_cnt == MAX_WAIT) | ~core_req);
  assign core_win   = core_req & ~acc_win;
  assign core_legal = core_win & ~core_err;

  assign core_req_ack = core_win;
  assign acc_gnt      = acc_win;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    core_be = 4'hF;
    core_wd = core_wdata;
    case (core_width)
      2'd0: begin
        core_be = 4'b0001 << core_addr[1:0];
        core_wd = {4{core_wdata[7:0]}};
      end
      2'd1: begin
        core_be = core_addr[1] ? 4'b1100 : 4'b0011;
        core_wd = {2{core_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (acc_win) begin
      mem_ren   = ~acc_we;
      mem_wen   = acc_we;
      mem_be    = acc_be;
      mem_addr  = acc_addr;
      mem_wdata = acc_wdata;
    end else if (core_legal) begin
      mem_ren   = ~core_cmd;
      mem_wen   = core_cmd;
      mem_be    = core_be;
      mem_addr  = core_addr[IDX_W+1:2];
      mem_wdata = core_wd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (acc_req & ~acc_win) begin
      if (starve_cnt != MAX_WAIT) starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end

  // Ownership of the next cycle's read data is tracked per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q       <= RESP_NOTRDY;
      core_rd_pend <= 1'b0;
      core_shift   <= '0;
      acc_rd_pend  <= 1'b0;
    end else begin
      resp_q       <= core_win ? (core_err ? RESP_RDY_ER : RESP_RDY_OK) : RESP_NOTRDY;
      core_rd_pend <= core_legal & ~core_cmd;
      acc_rd_pend  <= acc_win & ~acc_we;
      if (core_legal & ~core_cmd) core_shift <= core_addr[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rdata_q <= '0;
    end else if (core_rd_pend) begin
      core_rdata_q <= core_rdata;
    end
  end

  assign core_rdata = core_rd_pend ? (mem_rdata >> {core_shift, 3'b000}) : core_rdata_q;
  assign core_resp  = resp_q;
  assign acc_rvalid = acc_rd_pend;
  assign acc_rdata  = acc_rd_pend ? mem_rdata : '0;

endmodule

// File: tb/tb_scr1_tcm_dport_arb.sv
// Bench for scr1_tcm_dport_arb: vector table, directed corner sequences and a random
// phase against a transaction-level model with its own copy of the memory contents.
module tb_scr1_tcm_dport_arb;

  localparam logic [31:0] TCM_SIZE = 32'h00010000;
  localparam int          MAXW     = 4;
  localparam int          IDX_W    = 14;
  localparam int          WORDS    = 1 << IDX_W;

  logic             clk;
  logic             rst_n;
  logic             core_req, core_cmd;
  logic [1:0]       core_width;
  logic [31:0]      core_addr, core_wdata;
  logic             core_req_ack;
  logic [31:0]      core_rdata;
  logic [1:0]       core_resp;
  logic             acc_req, acc_we;
  logic [3:0]       acc_be;
  logic [IDX_W-1:0] acc_addr;
  logic [31:0]      acc_wdata;
  logic             acc_gnt, acc_rvalid;
  logic [31:0]      acc_rdata;
  logic             mem_ren, mem_wen;
  logic [3:0]       mem_be;
  logic [IDX_W-1:0] mem_addr;
  logic [31:0]      mem_wdata, mem_rdata;

  scr1_tcm_dport_arb #(.TCM_SIZE(TCM_SIZE), .ACC_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_cmd(core_cmd), .core_width(core_width),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_req_ack(core_req_ack),
    .core_rdata(core_rdata), .core_resp(core_resp),
    .acc_req(acc_req), .acc_we(acc_we), .acc_be(acc_be), .acc_addr(acc_addr),
    .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-B memory driven by the DUT; ref_mem is the model's own view of the contents.
  logic [31:0] mem     [WORDS];
  logic [31:0] ref_mem [WORDS];

  always @(posedge clk) begin
    if (mem_wen)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_ren) mem_rdata <= mem[mem_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic cr, input logic cc, input logic [1:0] cw,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic ar, input logic aw, input logic [3:0] ab,
                       input logic [IDX_W-1:0] aa, input logic [31:0] ad);
    core_req = cr; core_cmd = cc; core_width = cw; core_addr = ca; core_wdata = cd;
    acc_req = ar; acc_we = aw; acc_be = ab; acc_addr = aa; acc_wdata = ad;
  endtask

  task automatic idle();
    drive(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 4'h0, '0, 32'h0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next();
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    logic             creq, ccmd;
    logic [1:0]       cw;
    logic [31:0]      caddr, cwd;
    logic             areq, awe;
    logic [3:0]       abe;
    logic [IDX_W-1:0] aaddr;
    logic [31:0]      awd;
    logic             ack, gnt, ren, wen;
    logic [3:0]       be;
    logic [IDX_W-1:0] maddr;
    logic [31:0]      mwd;
  } vec_t;

  vec_t vecs [14];

  // Transaction-level model state for the random phase.
  int          cnt;
  bit          cpend, apend;
  logic [31:0] cpend_val, apend_val, chold;
  logic [1:0]  resp_next;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = i * 32'h9E3779B9;
      ref_mem[i] = i * 32'h9E3779B9;
    end
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset core_resp", 32'(core_resp), 32'd0);
    check("reset core_rdata", core_rdata, 32'h0);
    check("reset acc_rvalid", 32'(acc_rvalid), 32'd0);
    check("reset acc_rdata", acc_rdata, 32'h0);
    check("reset ack", 32'(core_req_ack), 32'd0);
    check("reset gnt", 32'(acc_gnt), 32'd0);
    check("reset mem_ren/wen", {30'd0, mem_ren, mem_wen}, 32'd0);
    rst_n = 1'b1;
    next();

    // ---------------- single-cycle vector table ----------------
    //          creq ccmd cw  caddr         cwd            areq awe abe   aaddr     awd           ack gnt ren wen be    maddr     mwd
    vecs[0]  = '{0, 0, 2'd0, 32'h0,      32'h0,        0, 0, 4'h0, 14'h00, 32'h0,        0, 0, 0, 0, 4'h0, 14'h00, 32'h0};
    vecs[1]  = '{1, 1, 2'd2, 32'h10,     32'h12345678, 0, 0, 4'h0, 14'h00, 32'h0,        1, 0, 0, 1, 4'hF, 14'h04, 32'h12345678};
    vecs[2]  = '{1, 1, 2'd0, 32'h21,     32'h000000C3, 0, 0, 4'h0, 14'h00, 32'h0,        1, 0, 0, 1, 4'h2, 14'h08, 32'hC3C3C3C3};
    vecs[3]  = '{1, 1, 2'd1, 32'h22,     32'h0000BEEF, 0, 0, 4'h0, 14'h00, 32'h0,        1, 0, 0, 1, 4'hC, 14'h08, 32'hBEEFBEEF};
    vecs[4]  = '{1, 0, 2'd1, 32'h30,     32'h0,        0, 0, 4'h0, 14'h00, 32'h0,        1, 0, 1, 0, 4'h3, 14'h0C, 32'h0};
    vecs[5]  = '{1, 0, 2'd0, 32'h0,      32'h0,        0, 0, 4'h0, 14'h00, 32'h0,        1, 0, 1, 0, 4'h1, 14'h00, 32'h0};
    vecs[6]  = '{0, 0, 2'd0, 32'h0,      32'h0,        1, 1, 4'h5, 14'h10, 32'hCAFEF00D, 0, 1, 0, 1, 4'h5, 14'h10, 32'hCAFEF00D};
    vecs[7]  = '{0, 0, 2'd0, 32'h0,      32'h0,        1, 0, 4'h0, 14'h11, 32'h0,        0, 1, 1, 0, 4'h0, 14'h11, 32'h0};
    vecs[8]  = '{1, 0, 2'd2, 32'h40,     32'h0,        1, 1, 4'hF, 14'h12, 32'h55555555, 1, 0, 1, 0, 4'hF, 14'h10, 32'h0};
    vecs[9]  = '{1, 1, 2'd2, 32'h44,     32'h11112222, 1, 0, 4'h0, 14'h13, 32'h0,        1, 0, 0, 1, 4'hF, 14'h11, 32'h11112222};
    vecs[10] = '{1, 0, 2'd2, 32'h42,     32'h0,        0, 0, 4'h0, 14'h00, 32'h0,        1, 0, 0, 0, 4'h0, 14'h00, 32'h0};
    vecs[11] = '{1, 1, 2'd0, 32'h10000,  32'h000000FF, 0, 0, 4'h0, 14'h00, 32'h0,        1, 0, 0, 0, 4'h0, 14'h00, 32'h0};
    vecs[12] = '{1, 0, 2'd1, 32'h33,     32'h0,        1, 0, 4'h0, 14'h14, 32'h0,        1, 0, 0, 0, 4'h0, 14'h00, 32'h0};
    vecs[13] = '{0, 0, 2'd0, 32'h0,      32'h0,        0, 0, 4'h0, 14'h00, 32'h0,        0, 0, 0, 0, 4'h0, 14'h00, 32'h0};
    foreach (vecs[i]) begin
      drive(vecs[i].creq, vecs[i].ccmd, vecs[i].cw, vecs[i].caddr, vecs[i].cwd,
            vecs[i].areq, vecs[i].awe, vecs[i].abe, vecs[i].aaddr, vecs[i].awd);
      @(negedge clk);
      check($sformatf("vec%0d ack", i), 32'(core_req_ack), 32'(vecs[i].ack));
      check($sformatf("vec%0d gnt", i), 32'(acc_gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d ren", i), 32'(mem_ren), 32'(vecs[i].ren));
      check($sformatf("vec%0d wen", i), 32'(mem_wen), 32'(vecs[i].wen));
      check($sformatf("vec%0d be", i), 32'(mem_be), 32'(vecs[i].be));
      check($sformatf("vec%0d addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
      check($sformatf("vec%0d wdata", i), mem_wdata, vecs[i].mwd);
      next();
    end

    // ---------------- word write / read ----------------
    drive(1, 1, 2'd2, 32'h100, 32'hDEADBEEF, 0, 0, 4'h0, '0, 32'h0);
    @(negedge clk);
    check("ww wen", 32'(mem_wen), 32'd1);
    check("ww be", 32'(mem_be), 32'hF);
    check("ww addr", 32'(mem_addr), 32'h40);
    check("ww wdata", mem_wdata, 32'hDEADBEEF);
    next();
    drive(1, 0, 2'd2, 32'h100, 32'h0, 0, 0, 4'h0, '0, 32'h0);
    @(negedge clk);
    check("ww resp", 32'(core_resp), 32'd1);
    check("wr ren", 32'(mem_ren), 32'd1);
    check("wr be", 32'(mem_be), 32'hF);
    next();
    idle();
    @(negedge clk);
    check("wr resp", 32'(core_resp), 32'd1);
    check("wr rdata", core_rdata, 32'hDEADBEEF);
    next();

    // ---------------- byte write / read at 0x103 ----------------
    drive(1, 1, 2'd0, 32'h103, 32'h000000A5, 0, 0, 4'h0, '0, 32'h0);
    @(negedge clk);
    check("bw wdata", mem_wdata, 32'hA5A5A5A5);
    check("bw be", 32'(mem_be), 32'h8);
    next();
    drive(1, 0, 2'd0, 32'h103, 32'h0, 0, 0, 4'h0, '0, 32'h0);
    @(negedge clk);
    check("br be", 32'(mem_be), 32'h8);
    next();
    idle();
    @(negedge clk);
    check("br resp", 32'(core_resp), 32'd1);
    check("br rdata", core_rdata, 32'h000000A5);
    next();

    // ---------------- misaligned and out-of-range ----------------
    drive(1, 0, 2'd1, 32'h101, 32'h0, 0, 0, 4'h0, '0, 32'h0);
    @(negedge clk);
    check("mis ack", 32'(core_req_ack), 32'd1);
    check("mis ren", 32'(mem_ren), 32'd0);
    next();
    drive(1, 0, 2'd2, 32'h10000, 32'h0, 0, 0, 4'h0, '0, 32'h0);
    @(negedge clk);
    check("mis resp", 32'(core_resp), 32'd2);
    check("oor ack", 32'(core_req_ack), 32'd1);
    check("oor ren", 32'(mem_ren), 32'd0);
    next();
    idle();
    @(negedge clk);
    check("oor resp", 32'(core_resp), 32'd2);
    check("oor rdata hold", core_rdata, 32'h000000A5);
    next();
    @(negedge clk);
    check("idle resp", 32'(core_resp), 32'd0);
    next();

    // ---------------- starvation: acc wins on cycle 5 ----------------
    for (int c = 1; c <= 6; c++) begin
      drive(1, 0, 2'd2, 32'h100, 32'h0, 1, 0, 4'h0, 14'h40, 32'h0);
      @(negedge clk);
      check($sformatf("starve c%0d ack", c), 32'(core_req_ack), 32'(c != 5));
      check($sformatf("starve c%0d gnt", c), 32'(acc_gnt), 32'(c == 5));
      if (c == 6) begin
        check("starve rvalid", 32'(acc_rvalid), 32'd1);
        check("starve acc_rdata", acc_rdata, 32'hA5ADBEEF);
      end
      next();
    end
    idle();
    next();

    // ---------------- alternating owners ----------------
    drive(1, 0, 2'd2, 32'h100, 32'h0, 0, 0, 4'h0, '0, 32'h0);
    next();
    drive(0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 4'h0, 14'h40, 32'h0);
    @(negedge clk);
    check("alt1 resp", 32'(core_resp), 32'd1);
    check("alt1 rdata", core_rdata, 32'hA5ADBEEF);
    check("alt1 rvalid", 32'(acc_rvalid), 32'd0);
    next();
    drive(1, 0, 2'd0, 32'h101, 32'h0, 0, 0, 4'h0, '0, 32'h0);
    @(negedge clk);
    check("alt2 resp", 32'(core_resp), 32'd0);
    check("alt2 rvalid", 32'(acc_rvalid), 32'd1);
    check("alt2 acc_rdata", acc_rdata, 32'hA5ADBEEF);
    next();
    drive(0, 0, 2'd0, 32'h0, 32'h0, 1, 0, 4'h0, 14'h40, 32'h0);
    @(negedge clk);
    check("alt3 resp", 32'(core_resp), 32'd1);
    check("alt3 rdata", core_rdata, 32'h00A5ADBE);
    check("alt3 rvalid", 32'(acc_rvalid), 32'd0);
    next();
    idle();
    @(negedge clk);
    check("alt4 rvalid", 32'(acc_rvalid), 32'd1);
    check("alt4 resp", 32'(core_resp), 32'd0);
    check("alt4 rdata hold", core_rdata, 32'h00A5ADBE);
    next();

    // ---------------- reset right after a granted core read ----------------
    for (int c = 1; c <= 3; c++) begin
      drive(1, 0, 2'd2, 32'h100, 32'h0, 1, 0, 4'h0, 14'h40, 32'h0);
      @(negedge clk);
      check($sformatf("prerst c%0d ack", c), 32'(core_req_ack), 32'd1);
      next();
    end
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    check("rst resp", 32'(core_resp), 32'd0);
    check("rst rvalid", 32'(acc_rvalid), 32'd0);
    check("rst rdata", core_rdata, 32'h0);
    rst_n = 1'b1;
    next();
    for (int c = 1; c <= 5; c++) begin
      drive(1, 0, 2'd2, 32'h100, 32'h0, 1, 0, 4'h0, 14'h40, 32'h0);
      @(negedge clk);
      if (c == 1) check("postrst resp", 32'(core_resp), 32'd0);
      check($sformatf("postrst c%0d gnt", c), 32'(acc_gnt), 32'(c == 5));
      next();
    end

    // ---------------- random phase against the model ----------------
    do_reset();
    cnt = 0; cpend = 0; apend = 0; chold = '0; cpend_val = '0; apend_val = '0;
    resp_next = 2'd0;
    for (int n = 0; n < 600; n++) begin
      bit          err, a_win, c_win, ncpend, napend;
      int unsigned a4;
      logic [3:0]  e_be;
      logic [31:0] e_wd, e_cwd, ncval, naval;
      logic [IDX_W-1:0] e_addr;
      logic        e_ren, e_wen;

      core_req   = ($urandom_range(0, 3) != 0);
      core_cmd   = 1'($urandom_range(0, 1));
      core_width = 2'($urandom_range(0, 2));
      core_addr  = ($urandom_range(0, 7) == 0) ? 32'h10000 + $urandom_range(0, 255)
                                               : 32'h200 + $urandom_range(0, 63);
      core_wdata = $urandom;
      acc_req    = ($urandom_range(0, 1) != 0);
      acc_we     = 1'($urandom_range(0, 1));
      acc_be     = 4'($urandom_range(0, 15));
      acc_addr   = IDX_W'(32'h80 + $urandom_range(0, 15));
      acc_wdata  = $urandom;

      @(negedge clk);
      a4    = core_addr % 4;
      err   = core_req && (core_addr >= TCM_SIZE || (core_width == 1 && a4 % 2 != 0)
                           || (core_width == 2 && a4 != 0));
      a_win = acc_req && (cnt == MAXW || !core_req);
      c_win = core_req && !a_win;
      e_ren = 0; e_wen = 0; e_be = 0; e_addr = '0; e_wd = 0;
      e_cwd = (core_width == 0) ? core_wdata[7:0] * 32'h01010101
            : (core_width == 1) ? core_wdata[15:0] * 32'h00010001 : core_wdata;
      if (a_win) begin
        e_ren = !acc_we; e_wen = acc_we; e_be = acc_be; e_addr = acc_addr; e_wd = acc_wdata;
      end else if (c_win && !err) begin
        e_ren  = !core_cmd; e_wen = core_cmd;
        e_be   = (core_width == 0) ? 4'(1 << a4) : (core_width == 1) ? (a4 >= 2 ? 4'hC : 4'h3) : 4'hF;
        e_addr = IDX_W'(core_addr / 4);
        e_wd   = e_cwd;
      end
      check("rnd ack", 32'(core_req_ack), 32'(c_win));
      check("rnd gnt", 32'(acc_gnt), 32'(a_win));
      check("rnd ren", 32'(mem_ren), 32'(e_ren));
      check("rnd wen", 32'(mem_wen), 32'(e_wen));
      check("rnd be", 32'(mem_be), 32'(e_be));
      check("rnd addr", 32'(mem_addr), 32'(e_addr));
      check("rnd wdata", mem_wdata, e_wd);
      check("rnd resp", 32'(core_resp), 32'(resp_next));
      check("rnd core_rdata", core_rdata, cpend ? cpend_val : chold);
      check("rnd rvalid", 32'(acc_rvalid), 32'(apend));
      check("rnd acc_rdata", acc_rdata, apend ? apend_val : 32'h0);

      // Advance the model by one transaction.
      if (cpend) chold = cpend_val;
      resp_next = c_win ? (err ? 2'd2 : 2'd1) : 2'd0;
      ncpend = c_win && !err && !core_cmd;
      ncval  = ref_mem[e_addr] >> (8 * a4);
      napend = a_win && !acc_we;
      naval  = ref_mem[acc_addr];
      if (e_wen) ref_mem[e_addr] = merge(ref_mem[e_addr], e_wd, e_be);
      if (acc_req && !a_win) cnt = (cnt + 1 > MAXW) ? MAXW : cnt + 1;
      else cnt = 0;
      cpend = ncpend; cpend_val = ncval;
      apend = napend; apend_val = naval;
      next();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
